// File: rtl/glip_arb_pkg.sv
// -----------------------------------------------------------------------------
// glip_arb_pkg
// Shared types and helpers for the GLIP transmit channel arbiter:
//   - arb_state_e     : burst scheduler states (IDLE, HDR, DATA)
//   - calc_ch_bits    : width of the channel field, max(1, clog2(num_channels))
//   - calc_len_bits   : width of the burst-length field, clog2(max_burst+1)
//   - pack_header     : builds a burst header word (channel in the MSBs,
//                       length in the LSBs, all other bits zero)
// -----------------------------------------------------------------------------
package glip_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  // Widest word the header helper can build; callers truncate to their width.
  localparam int unsigned HDR_MAX_W = 64;

  function automatic int unsigned calc_ch_bits(input int unsigned num_channels);
    return (num_channels <= 32'd2) ? 32'd1 : $clog2(num_channels);
  endfunction

  function automatic int unsigned calc_len_bits(input int unsigned max_burst);
    return $clog2(max_burst + 32'd1);
  endfunction

  function automatic logic [HDR_MAX_W-1:0] pack_header(
    input logic [HDR_MAX_W-1:0] ch,
    input logic [HDR_MAX_W-1:0] len,
    input int unsigned          word_w,
    input int unsigned          ch_b,
    input int unsigned          len_b
  );
    logic [HDR_MAX_W-1:0] ch_mask;
    logic [HDR_MAX_W-1:0] len_mask;
    ch_mask  = (64'd1 << ch_b) - 64'd1;
    len_mask = (64'd1 << len_b) - 64'd1;
    return ((ch & ch_mask) << (word_w - ch_b)) | (len & len_mask);
  endfunction

endpackage

// File: rtl/glip_chan_fifo.sv
// -----------------------------------------------------------------------------
// glip_chan_fifo
// Single-clock per-channel buffer with an occupancy output.
// Ports:
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset (pointers and level cleared)
//   push_i   : write wdata_i (ignored while full)
//   pop_i    : drop the head word (ignored while empty)
//   wdata_i  : word to store
//   rdata_o  : current head word
//   level_o  : number of stored words (0..DEPTH)
//   ready_o  : buffer not full
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module glip_chan_fifo #(
  parameter  int unsigned WORD_WIDTH = 16,
  parameter  int unsigned DEPTH      = 8,
  localparam int unsigned PTR_W      = $clog2(DEPTH),
  localparam int unsigned LVL_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [WORD_WIDTH-1:0] wdata_i,
  output logic [WORD_WIDTH-1:0] rdata_o,
  output logic [LVL_W-1:0]      level_o,
  output logic                  ready_o
);

  logic [WORD_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  push_ok_s;
  logic                  pop_ok_s;

  assign ready_o   = (level_q < LVL_W'(DEPTH));
  assign push_ok_s = push_i & ready_o;
  assign pop_ok_s  = pop_i & (level_q != {LVL_W{1'b0}});
  assign rdata_o   = mem_q[rd_ptr_q];
  assign level_o   = level_q;

  // Storage write; contents need no reset because level gates every read.
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointer and level next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and level registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      level_q  <= {LVL_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/glip_tx_channel_arbiter.sv
// -----------------------------------------------------------------------------
// glip_tx_channel_arbiter
// Multiplexes NUM_CHANNELS producers onto the single GLIP outgoing FIFO port.
// Each channel is buffered locally; a round-robin scheduler emits bursts of
// one header word (channel in the MSBs, length in the LSBs) followed by
// 1..MAX_BURST data words from the granted channel.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   enable          : allow new bursts to start (running bursts always finish)
//   in_data         : channel c word at [c*WORD_WIDTH +: WORD_WIDTH]
//   in_valid/ready  : per-channel push handshake (ready = buffer not full)
//   fifo_out_*      : outgoing GLIP word stream (valid/ready)
//   busy            : a burst is in progress
//   cur_channel     : channel of the current or most recent burst
// Build option: define GLIP_ARB_CH0_PRIORITY_EN to make channel 0 win every
// arbitration while nonempty; the remaining channels rotate among themselves.
// -----------------------------------------------------------------------------
module glip_tx_channel_arbiter
  import glip_arb_pkg::*;
#(
  parameter  int unsigned WORD_WIDTH      = 16,
  parameter  int unsigned NUM_CHANNELS    = 4,
  parameter  int unsigned CHAN_FIFO_DEPTH = 8,
  parameter  int unsigned MAX_BURST       = 8,
  localparam int unsigned CH_BITS         = calc_ch_bits(NUM_CHANNELS)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enable,
  input  logic [NUM_CHANNELS*WORD_WIDTH-1:0] in_data,
  input  logic [NUM_CHANNELS-1:0]            in_valid,
  output logic [NUM_CHANNELS-1:0]            in_ready,
  output logic [WORD_WIDTH-1:0]              fifo_out_data,
  output logic                               fifo_out_valid,
  input  logic                               fifo_out_ready,
  output logic                               busy,
  output logic [CH_BITS-1:0]                 cur_channel
);

  localparam int unsigned LEN_BITS = calc_len_bits(MAX_BURST);
  localparam int unsigned LVL_W    = $clog2(CHAN_FIFO_DEPTH + 1);
  localparam logic [LVL_W-1:0]   MAXB_LVL = LVL_W'(MAX_BURST);
  localparam logic [CH_BITS:0]   NCH_W    = (CH_BITS + 1)'(NUM_CHANNELS);

  if ((CH_BITS + LEN_BITS > WORD_WIDTH) || (WORD_WIDTH > HDR_MAX_W)) begin : g_bad_cfg
    $error("glip_tx_channel_arbiter: header fields do not fit in WORD_WIDTH");
  end

  arb_state_e            state_q, state_d;
  logic [CH_BITS-1:0]    grant_q, grant_d;
  logic [CH_BITS-1:0]    last_grant_q, last_grant_d;
  logic [LEN_BITS-1:0]   len_q, len_d;
  logic [LEN_BITS-1:0]   rem_q, rem_d;

  logic [NUM_CHANNELS-1:0] push_s;
  logic [NUM_CHANNELS-1:0] pop_s;
  logic [NUM_CHANNELS-1:0] nonempty_s;
  logic [WORD_WIDTH-1:0]   head_s  [NUM_CHANNELS];
  logic [LVL_W-1:0]        level_s [NUM_CHANNELS];

  logic                    sel_found_s;
  logic [CH_BITS-1:0]      sel_ch_s;
  logic [CH_BITS:0]        rr_idx_s;
  logic                    rr_hit_s;
  logic [LVL_W-1:0]        lvl_sel_s;
  logic [LVL_W-1:0]        len_cand_s;
  logic [WORD_WIDTH-1:0]   hdr_s;
  logic                    xfer_s;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    assign push_s[c]     = in_valid[c] & in_ready[c];
    assign pop_s[c]      = (state_q == ST_DATA) & fifo_out_ready & (grant_q == CH_BITS'(c));
    assign nonempty_s[c] = (level_s[c] != {LVL_W{1'b0}});

    glip_chan_fifo #(
      .WORD_WIDTH (WORD_WIDTH),
      .DEPTH      (CHAN_FIFO_DEPTH)
    ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (rst),
      .push_i  (push_s[c]),
      .pop_i   (pop_s[c]),
      .wdata_i (in_data[c*WORD_WIDTH +: WORD_WIDTH]),
      .rdata_o (head_s[c]),
      .level_o (level_s[c]),
      .ready_o (in_ready[c])
    );
  end

  // Round-robin pick: first nonempty channel after last_grant, with wrap.
  always_comb begin
    sel_found_s = 1'b0;
    sel_ch_s    = {CH_BITS{1'b0}};
    rr_idx_s    = {(CH_BITS + 1){1'b0}};
    rr_hit_s    = 1'b0;
`ifdef GLIP_ARB_CH0_PRIORITY_EN
    sel_found_s = nonempty_s[0];
    for (int unsigned i = 1; i <= NUM_CHANNELS; i++) begin
      rr_idx_s = {1'b0, last_grant_q} + (CH_BITS + 1)'(i);
      rr_idx_s = (rr_idx_s >= NCH_W) ? (rr_idx_s - NCH_W) : rr_idx_s;
      // Channel 0 is handled by the priority path, never by the rotation.
      rr_hit_s = !sel_found_s && (rr_idx_s[CH_BITS-1:0] != {CH_BITS{1'b0}})
                 && nonempty_s[rr_idx_s[CH_BITS-1:0]];
      sel_ch_s    = rr_hit_s ? rr_idx_s[CH_BITS-1:0] : sel_ch_s;
      sel_found_s = sel_found_s | rr_hit_s;
    end
`else
    for (int unsigned i = 1; i <= NUM_CHANNELS; i++) begin
      rr_idx_s = {1'b0, last_grant_q} + (CH_BITS + 1)'(i);
      rr_idx_s = (rr_idx_s >= NCH_W) ? (rr_idx_s - NCH_W) : rr_idx_s;
      rr_hit_s = !sel_found_s && nonempty_s[rr_idx_s[CH_BITS-1:0]];
      sel_ch_s    = rr_hit_s ? rr_idx_s[CH_BITS-1:0] : sel_ch_s;
      sel_found_s = sel_found_s | rr_hit_s;
    end
`endif
  end

  // Burst length from the level seen this cycle; later pushes wait for the next burst.
  assign lvl_sel_s  = level_s[sel_ch_s];
  assign len_cand_s = (lvl_sel_s > MAXB_LVL) ? MAXB_LVL : lvl_sel_s;
  assign xfer_s     = fifo_out_valid & fifo_out_ready;
  assign hdr_s      = WORD_WIDTH'(pack_header(HDR_MAX_W'(grant_q), HDR_MAX_W'(len_q),
                                              WORD_WIDTH, CH_BITS, LEN_BITS));

  // Scheduler next-state.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    len_d        = len_q;
    rem_d        = rem_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (enable && sel_found_s) begin
          grant_d = sel_ch_s;
          len_d   = LEN_BITS'(len_cand_s);
          state_d = ST_HDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (xfer_s) begin
          rem_d   = len_q;
          state_d = ST_DATA;
        end else begin
          state_d = ST_HDR;
        end
      end
      ST_DATA: begin
        if (xfer_s) begin
          rem_d = rem_q - LEN_BITS'(1);
          if (rem_q == LEN_BITS'(1)) begin
`ifdef GLIP_ARB_CH0_PRIORITY_EN
            // Channel-0 bursts must not disturb the rotation of the others.
            last_grant_d = (grant_q == {CH_BITS{1'b0}}) ? last_grant_q : grant_q;
`else
            last_grant_d = grant_q;
`endif
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Scheduler registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= {CH_BITS{1'b0}};
      len_q        <= {LEN_BITS{1'b0}};
      rem_q        <= {LEN_BITS{1'b0}};
      last_grant_q <= CH_BITS'(NUM_CHANNELS - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      len_q        <= len_d;
      rem_q        <= rem_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Output word select; every source is held constant while a word is stalled.
  always_comb begin
    fifo_out_data = {WORD_WIDTH{1'b0}};
    case (state_q)
      ST_IDLE: fifo_out_data = {WORD_WIDTH{1'b0}};
      ST_HDR:  fifo_out_data = hdr_s;
      ST_DATA: fifo_out_data = head_s[grant_q];
      default: fifo_out_data = {WORD_WIDTH{1'b0}};
    endcase
  end

  assign fifo_out_valid = (state_q != ST_IDLE);
  assign busy           = (state_q != ST_IDLE);
  assign cur_channel    = grant_q;

endmodule
